jam_dp_engine: RTL and testbench
================================

Name: jam_dp_engine

Overview:
- Parametrised successor of the cell's job-assignment solver.
- Fetches an N×N worker/job cost matrix over a W/J address port.
- Computes minimum total assignment cost and the number of optimal assignments by bitmask dynamic programming.
- Adds a Start/Busy handshake so the block can be re-run without reset, and a saturating match count.

Parameters:
- N, 8, workers = jobs; legal range 2..8.
- AW, 3, W/J address width; requires N ≤ 2^AW.
- CW, 7, Cost input width (unsigned).
- MCW, 10, MinCost width; requires MCW ≥ CW + ceil(log2 N).
- CNTW, 4, MatchCount width; the count saturates at 2^CNTW−1.

Ports:
- CLK  in  1  Clock; all state updates on the rising edge.
- RST_N  in  1  Asynchronous, active-low reset.
- Start  in  1  Single-cycle run request; sampled only in IDLE.
- Busy  out  1  High from the edge after Start is accepted until the result is posted.
- W  out  AW  Worker index of the requested cost entry.
- J  out  AW  Job index of the requested cost entry.
- Cost  in  CW  Cost[W][J] from combinational memory; valid in the same cycle W/J are presented.
- Valid  out  1  High while MinCost/MatchCount hold a completed result.
- MinCost  out  MCW  Minimum total cost.
- MatchCount  out  CNTW  Number of minimum-cost assignments, saturating.

Behaviour:
- Reset (RST_N low, any time, including mid-run):
  - State goes to IDLE.
  - W, J, Busy, Valid, MinCost and MatchCount go to 0.
  - Internal counters and mask go to 0.
  - The run is aborted; there is no partial result.
- States and transitions:
  - IDLE → LOAD when Start=1.
  - LOAD → CALC after N*N fetch cycles.
  - CALC → DONE after the last transition.
  - DONE → IDLE in 1 cycle.
  - Start in LOAD, CALC or DONE is ignored (no queueing).
- Start accept edge:
  - Busy goes to 1 and Valid is cleared.
  - W and J go to 0.
  - dp[0] goes to 0 and dp[m] goes to all-ones for m ≠ 0.
  - cnt[m] goes to 1 for all m.
  - The previous MinCost/MatchCount values persist until overwritten.
- LOAD:
  - Each cycle, Cost is stored to table[W][J].
  - J increments. When J = N−1, J goes to 0 and W increments.
  - Order is row-major (W major), N*N cycles.
  - W/J are not used in other states and hold 0 there.
- CALC, mask traversal:
  - mask runs 0..2^N−2. Each mask occupies exactly N cycles, j = 0..N−1.
  - Worker index w = popcount(mask).
  - If mask bit j = 1, the cycle is idle (no write).
- CALC, DP update (otherwise): nm = mask | (1<<j), cand = dp[mask] + table[w][j], computed at full MCW width.
  - If cand < dp[nm]: dp[nm] ← cand and cnt[nm] ← cnt[mask].
  - If cand = dp[nm]: cnt[nm] ← sat(cnt[nm] + cnt[mask]), with saturation at 2^CNTW−1.
  - If cand > dp[nm]: no change.
- Unreachable/unused masks never feed a write: dp[mask] with popcount(mask) ≥ N is never read.
- DONE (1 cycle):
  - MinCost ← dp[2^N−1] and MatchCount ← cnt[2^N−1].
  - Valid ← 1 and Busy ← 0 on the same edge.
  - Valid stays high until the next accepted Start or reset.
- Latency: Valid rises exactly N*N + N*(2^N−1) + 1 edges after the Start-accept edge.
  - N=8: 2105 edges.
  - N=2: 11 edges.
- Back-to-back runs: Start may be asserted in the first IDLE cycle after DONE. The second run must not depend on leftover table/dp contents.
- Simultaneous events: RST_N low overrides everything. Start coinciding with the DONE edge is ignored.

Test Plan:
- N=8, Cost[w][j] = w + j → Valid after 2105 edges, MinCost = 56, MatchCount = 15 (40320 optimal assignments, saturated); Busy low on the Valid edge.
- N=4 (CNTW=4), Cost = 1 on the diagonal and 10 elsewhere → MinCost = 4, MatchCount = 1; W/J visit (0,0),(0,1)…(3,3) in 16 consecutive cycles.
- N=3, all Cost = 5 → MinCost = 15, MatchCount = 6 (no saturation); then a second Start with Cost[w][j] = 127 except Cost[2][0] = 0 → MinCost = 254, MatchCount = 2, with Valid low during the second run.
- N=8, all Cost = 127 → MinCost = 1016, no overflow at MCW = 10; MatchCount = 15.
- RST_N pulsed low mid-CALC → all outputs 0 immediately (asynchronously), state IDLE, Start ignored while RST_N is low; a subsequent full run gives the correct result.
- Start held high for the entire run → exactly one run; Start re-sampled only on return to IDLE, which launches a second run on the edge after DONE.

Source files
------------

// File: rtl/jam_dp_engine_if.sv
// Host-side bundle for jam_dp_engine: run handshake, cost fetch port and posted result.
interface jam_dp_engine_if #(
    parameter int AW   = 3,
    parameter int CW   = 7,
    parameter int MCW  = 10,
    parameter int CNTW = 4
);
    logic            Start;
    logic            Busy;
    logic [AW-1:0]   W;
    logic [AW-1:0]   J;
    logic [CW-1:0]   Cost;
    logic            Valid;
    logic [MCW-1:0]  MinCost;
    logic [CNTW-1:0] MatchCount;

    modport master (output Start, Cost, input Busy, W, J, Valid, MinCost, MatchCount);
    modport slave  (input Start, Cost, output Busy, W, J, Valid, MinCost, MatchCount);
endinterface

// File: rtl/jam_dp_engine.sv
// Job-assignment solver: fetches an NxN cost matrix, then runs bitmask DP to find the
// minimum total cost and the (saturating) number of assignments that reach it.
//
// state | meaning
// IDLE  | waiting for Start; last result held on MinCost/MatchCount
// LOAD  | fetching the cost matrix row-major, one entry per cycle
// CALC  | sweeping masks 0..2^N-2, N job slots per mask
// DONE  | posting dp/cnt of the full mask
module jam_dp_engine #(
    parameter int N    = 8,
    parameter int AW   = 3,
    parameter int CW   = 7,
    parameter int MCW  = 10,
    parameter int CNTW = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    jam_dp_engine_if.slave bus
);
    localparam int              NM        = 1 << N;
    localparam int              TD        = 1 << AW;
    localparam logic [N-1:0]    MASK_LAST = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]    MASK_FULL = {N{1'b1}};
    localparam logic [AW-1:0]   IDX_LAST  = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   w_q, j_q, jc_q;
    logic [N-1:0]    mask_q;
    logic            busy_q, valid_q;
    logic [MCW-1:0]  min_cost_q;
    logic [CNTW-1:0] match_q;

    logic [CW-1:0]   tbl [TD][TD];
    logic [MCW-1:0]  dp  [NM];
    logic [CNTW-1:0] cnt [NM];
    logic [NM-1:0]   touched;

    logic            load_last, calc_last, slot_free;
    logic [AW-1:0]   w_pop;
    logic [N-1:0]    bit_j, nm;
    logic [MCW-1:0]  dp_m, dp_nm, cand;
    logic [CNTW-1:0] cnt_m, cnt_sat;
    logic [CNTW:0]   cnt_sum;

    function automatic logic [AW-1:0] popcount(input logic [N-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) n += int'(m[i]);
        return AW'(n);
    endfunction

    assign load_last = (w_q == IDX_LAST) && (j_q == IDX_LAST);
    assign calc_last = (mask_q == MASK_LAST) && (jc_q == IDX_LAST);

    // An untouched entry reads as "infinite cost, one way": that is the run-start
    // initial value, applied lazily so a new run never sees leftover dp contents.
    always_comb begin
        w_pop     = popcount(mask_q);
        bit_j     = {{(N-1){1'b0}}, 1'b1} << jc_q;
        nm        = mask_q | bit_j;
        slot_free = ~|(mask_q & bit_j);
        dp_m      = (mask_q == '0) ? {MCW{1'b0}} : dp[mask_q];
        cnt_m     = (mask_q == '0) ? CNTW'(1) : cnt[mask_q];
        dp_nm     = touched[nm] ? dp[nm] : {MCW{1'b1}};
        cand      = dp_m + {{(MCW-CW){1'b0}}, tbl[w_pop][jc_q]};
        cnt_sum   = {1'b0, cnt[nm]} + {1'b0, cnt_m};
        cnt_sat   = cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Start) state_d = S_LOAD;
            S_LOAD:  if (load_last) state_d = S_CALC;
            S_CALC:  if (calc_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_q        <= '0;
            j_q        <= '0;
            jc_q       <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            min_cost_q <= '0;
            match_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        w_q     <= '0;
                        j_q     <= '0;
                        jc_q    <= '0;
                        mask_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (j_q == IDX_LAST) begin
                        j_q <= '0;
                        w_q <= load_last ? '0 : w_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_CALC: begin
                    if (jc_q == IDX_LAST) begin
                        jc_q   <= '0;
                        mask_q <= calc_last ? '0 : mask_q + 1'b1;
                    end else begin
                        jc_q <= jc_q + 1'b1;
                    end
                end
                S_DONE: begin
                    min_cost_q <= dp[MASK_FULL];
                    match_q    <= cnt[MASK_FULL];
                    valid_q    <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; every run rewrites the table and re-arms touched.
    always_ff @(posedge CLK) begin
        case (state_q)
            S_IDLE: if (bus.Start) touched <= '0;
            S_LOAD: tbl[w_q][j_q] <= bus.Cost;
            S_CALC: begin
                if (slot_free) begin
                    if (cand < dp_nm) begin
                        dp[nm]      <= cand;
                        cnt[nm]     <= cnt_m;
                        touched[nm] <= 1'b1;
                    end else if (cand == dp_nm) begin
                        cnt[nm] <= cnt_sat;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.Busy       = busy_q;
    assign bus.W          = w_q;
    assign bus.J          = j_q;
    assign bus.Valid      = valid_q;
    assign bus.MinCost    = min_cost_q;
    assign bus.MatchCount = match_q;
endmodule

// File: tb/tb_jam_dp_engine.sv
// Scoreboard bench for jam_dp_engine: instances with N=8, 4 and 3 share clock and reset;
// the driver queues expected results, a monitor pops and checks them as Valid rises.
module tb_jam_dp_engine;
    localparam int NI = 3;

    typedef struct packed {
        logic [9:0] mc;
        logic [3:0] cnt;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    logic       start_s [NI];
    logic [6:0] cmem    [NI][8][8];
    logic       busy_s  [NI];
    logic       valid_s [NI];
    logic [2:0] w_s     [NI];
    logic [2:0] j_s     [NI];
    logic [9:0] mc_s    [NI];
    logic [3:0] cnt_s   [NI];

    exp_t exp_q [NI][$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic int nval(input int g);
        return (g == 0) ? 8 : (g == 1) ? 4 : 3;
    endfunction

    function automatic int lat(input int g);
        int n;
        n = nval(g);
        return n * n + n * ((1 << n) - 1) + 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = (g == 0) ? 8 : (g == 1) ? 4 : 3;
        jam_dp_engine_if #(.AW(3), .CW(7), .MCW(10), .CNTW(4)) bus ();
        assign bus.Start  = start_s[g];
        assign bus.Cost   = cmem[g][bus.W][bus.J];
        assign busy_s[g]  = bus.Busy;
        assign valid_s[g] = bus.Valid;
        assign w_s[g]     = bus.W;
        assign j_s[g]     = bus.J;
        assign mc_s[g]    = bus.MinCost;
        assign cnt_s[g]   = bus.MatchCount;
        jam_dp_engine #(.N(NG), .AW(3), .CW(7), .MCW(10), .CNTW(4)) dut (
            .CLK   (CLK),
            .RST_N (RST_N),
            .bus   (bus)
        );
    end

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0d expected %0d", name, g, act, exp);
    endtask

    // Monitor
    int   k      [NI];
    int   wt     [NI];
    logic pb     [NI];
    logic pv     [NI];
    logic seq_ok [NI];

    initial begin
        int   n, ew, ej;
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            k[g] = 0; wt[g] = 0; pb[g] = 1'b0; pv[g] = 1'b0; seq_ok[g] = 1'b1;
        end
        forever begin
            @(negedge CLK or negedge RST_N);
            if (!RST_N) begin
                #1;
                for (int g = 0; g < NI; g++) begin
                    check("reset_outputs", g, 32'({busy_s[g], valid_s[g], w_s[g], j_s[g],
                                                  mc_s[g], cnt_s[g]}), 32'd0);
                    pb[g] = 1'b0;
                    pv[g] = 1'b0;
                end
            end else begin
                for (int g = 0; g < NI; g++) begin
                    n = nval(g);
                    if (busy_s[g] && !pb[g]) begin
                        k[g] = 0;
                        seq_ok[g] = 1'b1;
                    end else begin
                        k[g]++;
                    end
                    // k counts edges since accept: fetch order first, W/J parked at 0 afterwards
                    if (busy_s[g]) begin
                        ew = (k[g] < n * n) ? k[g] / n : 0;
                        ej = (k[g] < n * n) ? k[g] % n : 0;
                        if (w_s[g] !== 3'(ew) || j_s[g] !== 3'(ej) || valid_s[g] !== 1'b0)
                            seq_ok[g] = 1'b0;
                    end
                    if (exp_q[g].size() != 0) wt[g]++;
                    if (valid_s[g] && !pv[g]) begin
                        if (exp_q[g].size() == 0) begin
                            check("unexpected_valid", g, 32'(valid_s[g]), 32'd0);
                        end else begin
                            e = exp_q[g].pop_front();
                            wt[g] = 0;
                            check("min_cost", g, 32'(mc_s[g]), 32'(e.mc));
                            check("match_count", g, 32'(cnt_s[g]), 32'(e.cnt));
                            check("latency", g, 32'(k[g]), 32'(lat(g)));
                            check("busy_at_valid", g, 32'(busy_s[g]), 32'd0);
                            check("fetch_seq", g, 32'(seq_ok[g]), 32'd1);
                        end
                    end else if (exp_q[g].size() != 0 && wt[g] > lat(g) + 20) begin
                        check("timeout_valid", g, 32'(valid_s[g]), 32'd1);
                        void'(exp_q[g].pop_front());
                        wt[g] = 0;
                    end
                    pb[g] = busy_s[g];
                    pv[g] = valid_s[g];
                end
            end
        end
    end

    // 0: w+j  1: diag 1 else 10  2: all 5  3: 127 except [2][0]=0  4: all 127  5: (w+1)*(j+1)
    task automatic fill(input int g, input int mode);
        int v;
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0:       v = w + j;
                    1:       v = (w == j) ? 1 : 10;
                    2:       v = 5;
                    3:       v = (w == 2 && j == 0) ? 0 : 127;
                    4:       v = 127;
                    default: v = (w + 1) * (j + 1);
                endcase
                cmem[g][w][j] = 7'(v);
            end
        end
    endtask

    task automatic expect_res(input int g, input int mc, input int c);
        exp_t e;
        e.mc  = 10'(mc);
        e.cnt = 4'(c);
        exp_q[g].push_back(e);
    endtask

    task automatic start_run(input int g);
        start_s[g] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[g] = 1'b0;
    endtask

    task automatic wait_drain(input int g, input int depth);
        int t;
        t = 0;
        while (exp_q[g].size() > depth && t < 3000) begin
            @(negedge CLK);
            #2;
            t++;
        end
        if (exp_q[g].size() > depth) begin
            $display("FAIL drain inst%0d: %0d results still pending", g, exp_q[g].size());
            $fatal(1, "bench stalled");
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            start_s[g] = 1'b0;
            fill(g, 2);
        end
        #1 RST_N = 1'b0;
        start_s[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #2 start_s[0] = 1'b0;
        @(posedge CLK);
        #3 RST_N = 1'b1;

        fill(0, 0); expect_res(0, 56, 15); start_run(0); wait_drain(0, 0);
        fill(1, 1); expect_res(1, 4, 1);   start_run(1); wait_drain(1, 0);

        // Second run issued in the first IDLE cycle after DONE, with a new matrix
        fill(2, 2); expect_res(2, 15, 6);  start_run(2); wait_drain(2, 0);
        fill(2, 3); expect_res(2, 254, 2); start_run(2); wait_drain(2, 0);

        fill(0, 4); expect_res(0, 1016, 15); start_run(0); wait_drain(0, 0);

        // Abort mid-CALC; Start held through reset must not launch anything
        fill(1, 1); start_run(1);
        repeat (40) @(posedge CLK);
        #3 RST_N = 1'b0;
        start_s[1] = 1'b1;
        repeat (3) @(posedge CLK);
        #2 start_s[1] = 1'b0;
        @(posedge CLK);
        #3 RST_N = 1'b1;
        fill(1, 5); expect_res(1, 20, 1); start_run(1); wait_drain(1, 0);

        // Start held across a whole run: relaunch exactly on the edge after DONE
        fill(2, 2); expect_res(2, 15, 6); expect_res(2, 15, 6);
        start_s[2] = 1'b1;
        wait_drain(2, 1);
        @(posedge CLK);
        #1 start_s[2] = 1'b0;
        wait_drain(2, 0);

        repeat (5) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
